// File: rtl/led_blinker_pkg.sv
// Shared types and helpers for the multi-channel LED pattern blinker.
package led_blinker_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        PH_OFF = 2'd0,
        PH_ON  = 2'd1,
        GAP    = 2'd2
    } phase_t;

    function automatic int unsigned rate_half_period(
        input logic [1:0]  sel,
        input int unsigned r0,
        input int unsigned r1,
        input int unsigned r2,
        input int unsigned r3
    );
        case (sel)
            2'd0:    return r0;
            2'd1:    return r1;
            2'd2:    return r2;
            default: return r3;
        endcase
    endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: half-period counter, latched mode/rate/length, burst phase FSM.
module led_blink_channel
    import led_blinker_pkg::*;
#(
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned C_RATE0 = 10,
    parameter int unsigned C_RATE1 = 20,
    parameter int unsigned C_RATE2 = 50,
    parameter int unsigned C_RATE3 = 100,
    parameter int unsigned BURST_W = 3,
    parameter int unsigned GAP_HP  = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [1:0]         i_rate_sel,
    input  logic [1:0]         i_mode,
    input  logic [BURST_W-1:0] i_burst_len,
    output logic               o_led_drive,
    output logic               o_burst_done
);

    localparam int unsigned GAP_W = (GAP_HP > 1) ? $clog2(GAP_HP) : 1;

    mode_t              mode_q,  mode_d;
    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [CNT_W-1:0]   half_q,  half_d;
    logic [BURST_W-1:0] len_q,   len_d;
    logic [BURST_W-1:0] pulse_q, pulse_d;
    logic [GAP_W-1:0]   gap_q,   gap_d;
    logic               led_q,   led_d;
    logic               done_q,  done_d;

    logic [CNT_W-1:0]   rate_hp;
    logic [BURST_W-1:0] pulse_inc;
    logic               tc;
    logic               restart;

    assign rate_hp   = CNT_W'(rate_half_period(i_rate_sel, C_RATE0, C_RATE1, C_RATE2, C_RATE3));
    assign pulse_inc = pulse_q + BURST_W'(1);
    assign tc        = (cnt_q == half_q - CNT_W'(1));
    assign restart   = !i_enable || (mode_t'(i_mode) != mode_q);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mode_q  <= MODE_OFF;
            phase_q <= PH_OFF;
            cnt_q   <= '0;
            half_q  <= '0;
            len_q   <= '0;
            pulse_q <= '0;
            gap_q   <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            len_q   <= len_d;
            pulse_q <= pulse_d;
            gap_q   <= gap_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        len_d   = len_q;
        pulse_d = pulse_q;
        gap_d   = gap_q;
        led_d   = led_q;
        done_d  = 1'b0;

        // Restart wins over any terminal count seen on the same cycle.
        if (restart) begin
            mode_d  = mode_t'(i_mode);
            phase_d = PH_OFF;
            cnt_d   = '0;
            half_d  = rate_hp;
            len_d   = i_burst_len;
            pulse_d = '0;
            gap_d   = '0;
            led_d   = 1'b0;
        end else begin
            case (mode_q)
                MODE_OFF: begin
                    cnt_d = '0;
                    led_d = 1'b0;
                end
                MODE_ON: begin
                    cnt_d = '0;
                    led_d = 1'b1;
                end
                MODE_BLINK: begin
                    if (tc) begin
                        cnt_d  = '0;
                        half_d = rate_hp;
                        led_d  = !led_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    if (tc) begin
                        cnt_d  = '0;
                        half_d = rate_hp;
                        case (phase_q)
                            PH_OFF: begin
                                // A zero length keeps the channel dark and polls for a new length.
                                if (len_q == '0) begin
                                    len_d = i_burst_len;
                                end else begin
                                    phase_d = PH_ON;
                                    led_d   = 1'b1;
                                end
                            end
                            PH_ON: begin
                                led_d   = 1'b0;
                                pulse_d = pulse_inc;
                                if (pulse_inc == len_q) begin
                                    phase_d = GAP;
                                    gap_d   = '0;
                                    done_d  = 1'b1;
                                end else begin
                                    phase_d = PH_OFF;
                                end
                            end
                            GAP: begin
                                if (gap_q == GAP_W'(GAP_HP - 1)) begin
                                    phase_d = PH_OFF;
                                    len_d   = i_burst_len;
                                    pulse_d = '0;
                                end else begin
                                    gap_d = gap_q + GAP_W'(1);
                                end
                            end
                            default: begin
                                phase_d = PH_OFF;
                                led_d   = 1'b0;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign o_led_drive  = led_q;
    assign o_burst_done = done_q;

endmodule

// File: rtl/led_pattern_blinker.sv
// Multi-channel LED pattern blinker: NUM_CH independent channels sliced from packed buses.
module led_pattern_blinker
    import led_blinker_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned C_RATE0 = 10,
    parameter int unsigned C_RATE1 = 20,
    parameter int unsigned C_RATE2 = 50,
    parameter int unsigned C_RATE3 = 100,
    parameter int unsigned BURST_W = 3,
    parameter int unsigned GAP_HP  = 4
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [2*NUM_CH-1:0]       i_rate_sel,
    input  logic [2*NUM_CH-1:0]       i_mode,
    input  logic [BURST_W*NUM_CH-1:0] i_burst_len,
    output logic [NUM_CH-1:0]         o_led_drive,
    output logic [NUM_CH-1:0]         o_burst_done
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        led_blink_channel #(
            .CNT_W   (CNT_W),
            .C_RATE0 (C_RATE0),
            .C_RATE1 (C_RATE1),
            .C_RATE2 (C_RATE2),
            .C_RATE3 (C_RATE3),
            .BURST_W (BURST_W),
            .GAP_HP  (GAP_HP)
        ) u_ch (
            .i_clock      (i_clock),
            .i_reset      (i_reset),
            .i_enable     (i_enable),
            .i_rate_sel   (i_rate_sel[2*k +: 2]),
            .i_mode       (i_mode[2*k +: 2]),
            .i_burst_len  (i_burst_len[BURST_W*k +: BURST_W]),
            .o_led_drive  (o_led_drive[k]),
            .o_burst_done (o_burst_done[k])
        );
    end

endmodule

// File: tb/tb_led_pattern_blinker.sv
// Scoreboard bench: stimulus queues expected LED/done values per cycle, monitor checks on negedge.
module tb_led_pattern_blinker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  rate_sel;
    logic [7:0]  mode;
    logic [11:0] burst_len;
    logic [3:0]  led;
    logic [3:0]  done;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        int         cyc;
        logic [3:0] mask;
        logic [3:0] led;
        logic [3:0] done;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    led_pattern_blinker dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_rate_sel   (rate_sel),
        .i_mode       (mode),
        .i_burst_len  (burst_len),
        .o_led_drive  (led),
        .o_burst_done (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation whose cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_tests++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if ((((led ^ e.led) | (done ^ e.done)) & e.mask) != 4'b0) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: led=%b done=%b, required led=%b done=%b (mask %b)",
                         e.name, cyc, led, done, e.led, e.done, e.mask);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_at(input string nm, input int off, input logic [3:0] m,
                             input logic [3:0] l, input logic [3:0] d);
        exp_t x;
        x.name = nm;
        x.cyc  = cyc + off;
        x.mask = m;
        x.led  = l;
        x.done = d;
        sb.push_back(x);
    endtask

    task automatic burst_pattern(input string nm, input int base);
        expect_at({nm, "_off1"},  base + 9,  4'b0010, 4'b0000, 4'b0000);
        expect_at({nm, "_on1"},   base + 10, 4'b0010, 4'b0010, 4'b0000);
        expect_at({nm, "_off2"},  base + 20, 4'b0010, 4'b0000, 4'b0000);
        expect_at({nm, "_on2"},   base + 30, 4'b0010, 4'b0010, 4'b0000);
        expect_at({nm, "_off3"},  base + 40, 4'b0010, 4'b0000, 4'b0000);
        expect_at({nm, "_on3"},   base + 50, 4'b0010, 4'b0010, 4'b0000);
        expect_at({nm, "_done"},  base + 60, 4'b0010, 4'b0000, 4'b0010);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        mode      = 8'hAA;
        rate_sel  = 8'h00;
        burst_len = 12'h6DB;

        // Reset held for three edges, then all BLINK channels restart together.
        expect_at("rst_e1", 1, 4'hF, 4'h0, 4'h0);
        expect_at("rst_e2", 2, 4'hF, 4'h0, 4'h0);
        expect_at("rst_e3", 3, 4'hF, 4'h0, 4'h0);
        step(3);
        rst = 1'b0;
        expect_at("rst_rel_low",  10, 4'hF, 4'h0, 4'h0);
        expect_at("rst_rel_high", 11, 4'hF, 4'hF, 4'h0);
        step(12);

        // BLINK ch0 rate 0 from enable rise, then rate change mid-high.
        en   = 1'b0;
        mode = 8'h02;
        step(1);
        expect_at("en_low", 1, 4'hF, 4'h0, 4'h0);
        step(2);
        en = 1'b1;
        expect_at("blk_lo9",   9,  4'h1, 4'h0, 4'h0);
        expect_at("blk_hi10",  10, 4'h1, 4'h1, 4'h0);
        expect_at("blk_hi19",  19, 4'h1, 4'h1, 4'h0);
        expect_at("blk_lo20",  20, 4'h1, 4'h0, 4'h0);
        expect_at("blk_lo29",  29, 4'h1, 4'h0, 4'h0);
        expect_at("blk_hi30",  30, 4'h1, 4'h1, 4'h0);
        step(35);
        rate_sel = 8'h03;
        expect_at("rate_hi_kept", 4,   4'h1, 4'h1, 4'h0);
        expect_at("rate_lo_at10", 5,   4'h1, 4'h0, 4'h0);
        expect_at("rate_lo_99",   104, 4'h1, 4'h0, 4'h0);
        expect_at("rate_hi_100",  105, 4'h1, 4'h1, 4'h0);
        step(106);

        // BURST ch1, length 3, rate 0: 3 pulses, done, 40-clock gap, repeat.
        en        = 1'b0;
        mode      = 8'h0C;
        rate_sel  = 8'h00;
        burst_len = 12'h018;
        step(2);
        en = 1'b1;
        burst_pattern("bst", 0);
        expect_at("bst_on3_end",  59,  4'b0010, 4'b0010, 4'b0000);
        // Re-sort: the above must precede the done check, so rebuild the tail in order.
        sb.pop_back();
        e = sb.pop_back();
        expect_at("bst_on3_end",  59,  4'b0010, 4'b0010, 4'b0000);
        sb.push_back(e);
        expect_at("bst_done_end", 61,  4'b0010, 4'b0000, 4'b0000);
        expect_at("bst_gap_end",  109, 4'b0010, 4'b0000, 4'b0000);
        expect_at("bst_rpt_on",   110, 4'b0010, 4'b0010, 4'b0000);
        expect_at("bst_rpt_done", 160, 4'b0010, 4'b0000, 4'b0010);
        step(162);

        // Mode change on ch2: BLINK mid-high -> ON -> OFF.
        en   = 1'b0;
        mode = 8'h20;
        step(2);
        en = 1'b1;
        step(15);
        mode = 8'h10;
        expect_at("mc_on_gap",  1,  4'b0100, 4'b0000, 4'b0000);
        expect_at("mc_on_high", 2,  4'b0100, 4'b0100, 4'b0000);
        expect_at("mc_on_hold", 10, 4'b0100, 4'b0100, 4'b0000);
        step(10);
        mode = 8'h00;
        expect_at("mc_off_next", 1, 4'b0100, 4'b0000, 4'b0000);
        expect_at("mc_off_hold", 5, 4'b0100, 4'b0000, 4'b0000);
        step(6);

        // Abort via enable during second burst pulse, then fresh restart.
        en   = 1'b0;
        mode = 8'h0C;
        step(2);
        en = 1'b1;
        expect_at("ab_en_pulse2", 31, 4'b0010, 4'b0010, 4'b0000);
        step(33);
        en = 1'b0;
        expect_at("ab_en_clear", 1, 4'hF, 4'h0, 4'h0);
        expect_at("ab_en_held",  3, 4'hF, 4'h0, 4'h0);
        step(4);
        en = 1'b1;
        burst_pattern("ab_en_re", 0);
        step(62);

        // Abort via reset during second burst pulse.
        en = 1'b0;
        step(2);
        en = 1'b1;
        expect_at("ab_rst_pulse2", 31, 4'b0010, 4'b0010, 4'b0000);
        step(33);
        rst = 1'b1;
        expect_at("ab_rst_clear", 1, 4'hF, 4'h0, 4'h0);
        expect_at("ab_rst_held",  2, 4'hF, 4'h0, 4'h0);
        step(2);
        rst = 1'b0;
        burst_pattern("ab_rst_re", 1);
        step(63);

        step(2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
